// File: rtl/div_iter_sequencer_pkg.sv
// Shared types and sizing helpers for the divider iteration sequencer.
package div_pkg;

  localparam int DIV_XLEN = 32;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_e;

  function automatic int div_cnt_w(input int xlen);
    return $clog2(xlen + 1);
  endfunction

endpackage

// File: rtl/div_iter_sequencer_if.sv
// Issue-side and writeback-side signals of the divider iteration sequencer.
interface div_iter_sequencer_if #(
  parameter int CNT_W = div_pkg::div_cnt_w(div_pkg::DIV_XLEN)
);
  logic             start;
  logic [CNT_W-1:0] iter_req;
  logic             en;
  logic             flush;
  logic             out_ready;
  logic             in_ready;
  logic             busy;
  logic             step;
  logic             first;
  logic             last;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] iter_idx;
  logic             done_valid;

  modport master (
    output start, iter_req, en, flush, out_ready,
    input  in_ready, busy, step, first, last, count, iter_idx, done_valid
  );

  modport slave (
    input  start, iter_req, en, flush, out_ready,
    output in_ready, busy, step, first, last, count, iter_idx, done_valid
  );
endinterface

// File: rtl/div_iter_sequencer_step_counter.sv
// Loadable, enabled down-counter that saturates at zero; clear beats load beats decrement.
module div_step_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/div_iter_sequencer.sv
// Start/busy/done sequencer for the radix-2 divider: counts run-time iterations,
// honours stall and flush, and holds the result until writeback accepts it.
module div_iter_sequencer
  import div_pkg::*;
#(
  parameter int XLEN     = DIV_XLEN,
  parameter int CNT_W    = div_cnt_w(XLEN),
  parameter int MAX_ITER = XLEN
) (
  input logic                 clk,
  input logic                 reset,
  div_iter_sequencer_if.slave bus
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ITER);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] iter_idx_q, iter_idx_d;
  logic [CNT_W-1:0] n_clamp;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             busy, step, accept;

  assign n_clamp = (bus.iter_req > MAX_C) ? MAX_C : bus.iter_req;
  assign busy    = (state_q == DIV_RUN);
  assign step    = busy && bus.en;
  // A start coinciding with flush is dropped rather than queued.
  assign accept  = (state_q == DIV_IDLE) && bus.start && !bus.flush;

  always_comb begin
    state_d    = state_q;
    iter_idx_d = iter_idx_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (bus.start) begin
          iter_idx_d = '0;
          state_d    = (n_clamp == '0) ? DIV_DONE : DIV_RUN;
        end
      end
      DIV_RUN: begin
        if (step) begin
          iter_idx_d = (iter_idx_q == MAX_C) ? MAX_C : iter_idx_q + CNT_W'(1);
          if (cnt_zero) begin
            state_d = DIV_DONE;
          end
        end
      end
      DIV_DONE: begin
        if (bus.out_ready) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
    if (bus.flush) begin
      state_d    = DIV_IDLE;
      iter_idx_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= DIV_IDLE;
      iter_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      iter_idx_q <= iter_idx_d;
    end
  end

  div_step_counter #(.W(CNT_W)) u_count (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (bus.flush),
    .load_i     (accept && (n_clamp != '0)),
    .load_val_i (n_clamp - CNT_W'(1)),
    .dec_i      (step),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  assign bus.in_ready   = (state_q == DIV_IDLE);
  assign bus.busy       = busy;
  assign bus.step       = step;
  assign bus.first      = step && (iter_idx_q == '0);
  assign bus.last       = step && cnt_zero;
  assign bus.count      = cnt;
  assign bus.iter_idx   = iter_idx_q;
  assign bus.done_valid = (state_q == DIV_DONE);
endmodule

// File: doc/div_iter_sequencer.md
Name: div_iter_sequencer

Overview:
- Parametrised iteration sequencer for the multi-cycle radix-2 divider in the M-extension datapath.
- Generalises the fixed-value loadable down-counter into a start/busy/done sequencer with:
  - a run-time iteration count (for early termination after leading-zero skip), stall, flush, a terminal-step flag and an up-counting bit index;
  - a valid/ready result handshake toward writeback.
- Sits between the decode/issue stage and the divider shift/subtract datapath.

Parameters:
- XLEN, 32, operand width; maximum number of iterations.
- CNT_W, $clog2(XLEN+1), width of count, index and iteration-request fields.
- MAX_ITER, XLEN, clamp value for requested iterations (must be ≤ 2^CNT_W − 1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a new division; accepted only when in_ready=1.
- iter_req  in  CNT_W  requested iterations for this op; sampled with an accepted start.
- en  in  1  datapath advance enable; 0 = stall (RUN state holds).
- flush  in  1  pipeline kill; aborts any op in flight.
- out_ready  in  1  writeback can accept the result.
- in_ready  out  1  sequencer idle, can accept start.
- busy  out  1  in RUN state.
- step  out  1  datapath performs one iteration this cycle (busy & en).
- first  out  1  current step is the first iteration of the op (iter_idx==0).
- last  out  1  current step is the final iteration (count==0 in RUN).
- count  out  CNT_W  remaining iterations minus one.
- iter_idx  out  CNT_W  completed-iteration index (quotient bit position from MSB).
- done_valid  out  1  result ready for writeback.

Behaviour:
- Reset (asynchronous, active-high) forces the following, held while reset=1:
  - state=IDLE, count=0, iter_idx=0;
  - in_ready=1;
  - busy, step, first, last and done_valid all 0.
- States are IDLE, RUN and DONE. Outputs are Moore, except step, first and last, which are gated with en.
- IDLE:
  - in_ready=1.
  - Accepted start with n=min(iter_req, MAX_ITER):
    - n=0 → DONE next cycle; zero-iteration shortcut used for divide-by-zero and trivial quotients.
    - n>0 → RUN, with count=n−1 and iter_idx=0.
- RUN:
  - en=1: step=1; count decrements and iter_idx increments each cycle.
  - en=0: all registers hold, step=0.
  - When step & last (count==0), the next state is DONE.
  - count never wraps below 0.
  - Latency from start acceptance to done_valid is exactly n+1 cycles with en held high, plus one cycle per stall cycle.
- DONE:
  - done_valid=1, held until out_ready=1, then → IDLE next cycle.
  - start is ignored while in DONE (in_ready=0); no back-to-back overlap.
- flush has highest priority in any state:
  - next cycle state=IDLE, count=0, iter_idx=0, done_valid=0;
  - a start in the same cycle as flush is dropped.
- start while in RUN or DONE is ignored and produces no side effects.
- Simultaneous out_ready and start in DONE → IDLE only; start must be re-presented.
- iter_req > MAX_ITER is clamped to MAX_ITER.
- iter_idx saturates at MAX_ITER.

Decomposition:
- Shared package div_pkg holds:
  - the state enum (DIV_IDLE, DIV_RUN, DIV_DONE);
  - the CNT_W derivation function;
  - the default XLEN.
- One sub-module, div_step_counter: a loadable, enabled down-counter of width CNT_W.
  - Asynchronous active-high reset, load value as an input port, and a zero flag.
  - Instantiated once for count.
- iter_idx stays as an inline register in the top.

Test Plan:
1. Reset: assert reset mid-RUN at count=17 → all outputs at reset values immediately (asynchronous); in_ready=1 after release.
2. Basic op: start, iter_req=32, en=1 → busy for 32 cycles; first on cycle 1 only, last on cycle 32 only; iter_idx 0..31; done_valid on cycle 33; out_ready=1 → IDLE.
3. Stall: iter_req=4, en low for 3 cycles after step 2 → count and iter_idx hold; done_valid at cycle 8; exactly 4 step pulses.
4. Zero and clamp: iter_req=0 → done_valid the next cycle, no step. iter_req=63 with XLEN=32 → exactly 32 steps.
5. Flush: flush at step 10 of 32 → IDLE next cycle, no done_valid. A start issued with flush is dropped; start one cycle later is accepted.
6. Backpressure: out_ready=0 for 5 cycles in DONE → done_valid held, start ignored, in_ready=0; out_ready=1 → IDLE.
